// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, funct3 codes and ALU operation encoding.
package ex_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // alt is funct7[5]; it selects SUB only for register-register ops, SRA for both.
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt,
                                            input logic allow_sub);
    alu_op_e op;
    case (funct3)
      F3_ADD:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_branch_stage_alu.sv
// Combinational XLEN-wide ALU; carry/overflow are meaningful only for ADD and SUB.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_carry,
  output logic            o_overflow,
  output logic            o_zero
);

  logic            w_is_sub;
  logic            w_is_arith;
  logic [XLEN-1:0] w_b_eff;
  logic [XLEN:0]   w_sum;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_is_sub   = (i_op == ALU_SUB);
  assign w_is_arith = (i_op == ALU_ADD) || w_is_sub;
  assign w_b_eff    = w_is_sub ? ~i_b : i_b;
  assign w_sum      = {1'b0, i_a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_is_sub};
  assign w_shamt    = i_b[SHAMT_W-1:0];

  // Result multiplexer
  always_comb begin
    o_result = w_sum[XLEN-1:0];
    case (i_op)
      ALU_ADD, ALU_SUB: o_result = w_sum[XLEN-1:0];
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      default:  o_result = w_sum[XLEN-1:0];
    endcase
  end

  assign o_carry    = w_is_arith & w_sum[XLEN];
  assign o_overflow = w_is_arith & (i_a[XLEN-1] == w_b_eff[XLEN-1]) &
                      (w_sum[XLEN-1] != i_a[XLEN-1]);
  assign o_zero     = (o_result == {XLEN{1'b0}});

endmodule

// File: rtl/ex_branch_stage.sv
// Execute stage: ALU ops, branch resolution and jumps into a single-entry EX/MEM slot
// with valid/ready flow control and a one-cycle fetch redirect pulse.
module ex_branch_stage
  import ex_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alusrc,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_zero,
  output logic            out_carry,
  output logic            out_overflow,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  alu_op_e         w_alu_op;
  logic [XLEN-1:0] w_alu_b, w_alu_result, w_result, w_target;
  logic [XLEN-1:0] w_pc_imm, w_pc_plus4;
  logic            w_alu_carry, w_alu_overflow, w_alu_zero;
  logic            w_we, w_redirect, w_flags_en, w_lt_s, w_accept;
  logic            w_unused_funct7;

  logic            r_out_valid, r_redirect_valid, r_we;
  logic            r_zero, r_carry, r_overflow;
  logic [XLEN-1:0] r_result, r_redirect_pc;
  logic [4:0]      r_rd;

  ex_alu #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_alu (
    .i_op       (w_alu_op),
    .i_a        (in_rs1_val),
    .i_b        (w_alu_b),
    .o_result   (w_alu_result),
    .o_carry    (w_alu_carry),
    .o_overflow (w_alu_overflow),
    .o_zero     (w_alu_zero)
  );

  assign w_pc_imm        = in_pc + in_imm;
  assign w_pc_plus4      = in_pc + XLEN'(3'd4);
  assign w_lt_s          = w_alu_result[XLEN-1] ^ w_alu_overflow;
  assign w_unused_funct7 = ^{in_funct7[6], in_funct7[4:0]};

  // Decode: pick ALU operation, result source, writeback and redirect target
  always_comb begin
    w_alu_op   = ALU_ADD;
    w_alu_b    = in_alusrc ? in_imm : in_rs2_val;
    w_result   = w_alu_result;
    w_we       = (in_rd != 5'd0);
    w_flags_en = 1'b1;
    w_redirect = 1'b0;
    w_target   = w_pc_imm;
    case (in_opcode)
      OPC_OP:     w_alu_op = alu_op_decode(in_funct3, in_funct7[5], 1'b1);
      OPC_OP_IMM: w_alu_op = alu_op_decode(in_funct3, in_funct7[5], 1'b0);
      OPC_BRANCH: begin
        // Branch compare reuses the subtractor flags: rs1 - rs2
        w_alu_op = ALU_SUB;
        w_alu_b  = in_rs2_val;
        w_result = w_pc_imm;
        w_we     = 1'b0;
        case (in_funct3)
          F3_BEQ:  w_redirect = w_alu_zero;
          F3_BNE:  w_redirect = !w_alu_zero;
          F3_BLT:  w_redirect = w_lt_s;
          F3_BGE:  w_redirect = !w_lt_s;
          F3_BLTU: w_redirect = !w_alu_carry;
          F3_BGEU: w_redirect = w_alu_carry;
          default: begin
            w_result   = {XLEN{1'b0}};
            w_flags_en = 1'b0;
          end
        endcase
      end
      OPC_JAL: begin
        w_result   = w_pc_plus4;
        w_flags_en = 1'b0;
        w_redirect = 1'b1;
      end
      OPC_JALR: begin
        w_alu_b    = in_imm;
        w_result   = w_pc_plus4;
        w_flags_en = 1'b0;
        w_redirect = 1'b1;
        w_target   = {w_alu_result[XLEN-1:1], 1'b0};
      end
      default: begin
        w_result   = {XLEN{1'b0}};
        w_we       = 1'b0;
        w_flags_en = 1'b0;
      end
    endcase
  end

  // The cycle after a redirect is wrong-path: in_ready stays high so it drains, but nothing is kept.
  assign in_ready = !r_out_valid || out_ready || r_redirect_valid;
  assign w_accept = in_valid && in_ready && !flush && !r_redirect_valid;

  // EX/MEM slot and redirect pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_we             <= 1'b0;
      r_zero           <= 1'b0;
      r_carry          <= 1'b0;
      r_overflow       <= 1'b0;
      r_result         <= {XLEN{1'b0}};
      r_rd             <= 5'd0;
      r_redirect_pc    <= {XLEN{1'b0}};
    end else if (flush) begin
      r_out_valid      <= 1'b0;
      r_redirect_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid      <= 1'b1;
      r_redirect_valid <= w_redirect;
      r_result         <= w_result;
      r_rd             <= in_rd;
      r_we             <= w_we;
      r_zero           <= w_flags_en & w_alu_zero;
      r_carry          <= w_flags_en & w_alu_carry;
      r_overflow       <= w_flags_en & w_alu_overflow;
      if (w_redirect) begin
        r_redirect_pc <= w_target;
      end
    end else begin
      r_out_valid      <= r_out_valid && !out_ready;
      r_redirect_valid <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_result;
  assign out_rd         = r_rd;
  assign out_we         = r_we;
  assign out_zero       = r_zero;
  assign out_carry      = r_carry;
  assign out_overflow   = r_overflow;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ex_branch_stage.sv
// Randomized self-checking bench for ex_branch_stage (XLEN=64 main DUT, XLEN=32 side DUT).
module tb_ex_branch_stage;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        we, z, c, v, redir;
    logic [63:0] tgt;
  } exp_t;

  logic        clk, rst_n, flush, in_valid, out_ready, in_alusrc;
  logic [63:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;

  logic        in_ready, out_valid, out_we, out_zero, out_carry, out_overflow, redirect_valid;
  logic [63:0] out_result, redirect_pc;
  logic [4:0]  out_rd;

  logic        s32_in_ready, s32_out_valid, s32_out_we, s32_zero, s32_carry, s32_ovf, s32_redir;
  logic [31:0] s32_result, s32_redirect_pc;
  logic [4:0]  s32_rd;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_valid, m_redir;
  exp_t m_ent, m32, saved;

  ex_branch_stage #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_alusrc(in_alusrc),
    .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_zero(out_zero), .out_carry(out_carry),
    .out_overflow(out_overflow), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  ex_branch_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s32_in_ready),
    .in_pc(in_pc[31:0]), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1_val(in_rs1_val[31:0]), .in_rs2_val(in_rs2_val[31:0]), .in_imm(in_imm[31:0]),
    .in_alusrc(in_alusrc), .in_rd(in_rd), .out_valid(s32_out_valid), .out_ready(out_ready),
    .out_result(s32_result), .out_rd(s32_rd), .out_we(s32_out_we), .out_zero(s32_zero),
    .out_carry(s32_carry), .out_overflow(s32_ovf), .redirect_valid(s32_redir),
    .redirect_pc(s32_redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sext(input logic [63:0] x, input int xl);
    return $signed(x << (64 - xl)) >>> (64 - xl);
  endfunction

  // Reference: what the instruction currently on the inputs should produce at width xl.
  function automatic exp_t model(input int xl);
    exp_t e;
    logic [63:0] mask, a, b, imm, pc, r;
    longint sa, sb;
    int sh;
    logic sub;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a   = in_rs1_val & mask;
    imm = in_imm & mask;
    pc  = in_pc & mask;
    b   = in_alusrc ? imm : (in_rs2_val & mask);
    e   = '0;
    e.rd = in_rd;
    case (in_opcode)
      7'h33, 7'h13: begin
        sa  = sext(a, xl);
        sb  = sext(b, xl);
        sh  = int'(b % 64'(xl));
        sub = (in_opcode == 7'h33) && (in_funct3 == 3'd0) && in_funct7[5];
        case (in_funct3)
          3'd0: r = sub ? a - b : a + b;
          3'd1: r = a << sh;
          3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
          3'd3: r = (a < b) ? 64'd1 : 64'd0;
          3'd4: r = a ^ b;
          3'd5: r = in_funct7[5] ? $unsigned(sa >>> sh) : a >> sh;
          3'd6: r = a | b;
          default: r = a & b;
        endcase
        r = r & mask;
        e.result = r;
        e.z  = (r == 64'd0);
        e.we = (in_rd != 5'd0);
        if (in_funct3 == 3'd0) begin
          e.c = sub ? (a >= b) : (r < a);
          e.v = (sub ? ((sa < 0) != (sb < 0)) : ((sa < 0) == (sb < 0))) &&
                ((sext(r, xl) < 0) != (sa < 0));
        end
      end
      7'h63: begin
        b  = in_rs2_val & mask;
        sa = sext(a, xl);
        sb = sext(b, xl);
        if (in_funct3 != 3'd2 && in_funct3 != 3'd3) begin
          r = (a - b) & mask;
          e.result = (pc + imm) & mask;
          e.tgt    = (pc + imm) & mask;
          e.z = (a == b);
          e.c = (a >= b);
          e.v = ((sa < 0) != (sb < 0)) && ((sext(r, xl) < 0) != (sa < 0));
          case (in_funct3)
            3'd0: e.redir = (a == b);
            3'd1: e.redir = (a != b);
            3'd4: e.redir = (sa < sb);
            3'd5: e.redir = (sa >= sb);
            3'd6: e.redir = (a < b);
            default: e.redir = (a >= b);
          endcase
        end
      end
      7'h6F, 7'h67: begin
        e.result = (pc + 64'd4) & mask;
        e.we     = (in_rd != 5'd0);
        e.redir  = 1'b1;
        e.tgt    = (in_opcode == 7'h6F) ? ((pc + imm) & mask) : (((a + imm) & mask) & ~64'd1);
      end
      default: e = e;
    endcase
    return e;
  endfunction

  // One clock: advance the reference slot from the current inputs, then compare after the edge.
  task automatic tick();
    exp_t e;
    logic rdy;
    rdy = !m_valid || out_ready || m_redir;
    e   = model(64);
    m32 = model(32);
    if (flush) begin
      m_valid = 1'b0;
      m_redir = 1'b0;
    end else if (in_valid && rdy && !m_redir) begin
      m_valid = 1'b1;
      m_ent   = e;
      m_redir = e.redir;
    end else begin
      if (out_ready) m_valid = 1'b0;
      m_redir = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("out_valid", out_valid, m_valid);
    check_val("redirect_valid", redirect_valid, m_redir);
    check_val("in_ready", in_ready, !m_valid || out_ready || m_redir);
    if (m_valid) begin
      check_val("out_result", out_result, m_ent.result);
      check_val("out_rd", out_rd, m_ent.rd);
      check_val("out_we", out_we, m_ent.we);
      check_val("out_zero", out_zero, m_ent.z);
      check_val("out_carry", out_carry, m_ent.c);
      check_val("out_overflow", out_overflow, m_ent.v);
    end
    if (m_redir) check_val("redirect_pc", redirect_pc, m_ent.tgt);
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [4:0] rd);
    in_opcode = opc; in_funct3 = f3; in_funct7 = f7; in_pc = pc;
    in_rs1_val = a; in_rs2_val = b; in_imm = imm; in_rd = rd;
    in_alusrc = (opc == 7'h13); in_valid = 1'b1; flush = 1'b0;
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_8000_0000;
      4: return 64'h7FFF_FFFF_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_inputs();
    logic [6:0] opcs [6] = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h03};
    in_valid   = ($urandom_range(0, 9) < 7);
    out_ready  = ($urandom_range(0, 9) < 7);
    flush      = ($urandom_range(0, 19) == 0);
    in_opcode  = opcs[$urandom_range(0, 5)];
    in_funct3  = 3'($urandom_range(0, 7));
    in_funct7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    in_pc      = {$urandom, $urandom} & ~64'h3;
    in_rs1_val = pick_val();
    in_rs2_val = ($urandom_range(0, 3) == 0) ? in_rs1_val : pick_val();
    in_imm     = ($urandom_range(0, 1) == 1) ? 64'($signed(12'($urandom))) : pick_val();
    in_alusrc  = (in_opcode == 7'h13);
    in_rd      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endtask

  initial begin
    rst_n = 1'b0; m_valid = 1'b0; m_redir = 1'b0; m_ent = '0;
    out_ready = 1'b1;
    set_op(7'h00, 3'd0, 7'h00, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0);
    in_valid = 1'b0;
    #12;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_redirect", redirect_valid, 1'b0);
    check_val("rst_result", out_result, 64'd0);
    check_val("rst_flags", {out_we, out_zero, out_carry, out_overflow}, 4'd0);
    check_val("rst_redirect_pc", redirect_pc, 64'd0);
    rst_n = 1'b1;
    tick();

    set_op(7'h33, 3'd0, 7'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd3);
    tick();
    check_val("add_valid", out_valid, 1'b1);
    check_val("add_result", out_result, 64'd0);
    check_val("add_flags_zcv_we", {out_zero, out_carry, out_overflow, out_we}, 4'b1101);
    in_valid = 1'b0; tick();

    set_op(7'h63, 3'd0, 7'h00, 64'h100, 64'd5, 64'd5, 64'h8, 5'd0);
    tick();
    check_val("beq_redirect", redirect_valid, 1'b1);
    check_val("beq_target", redirect_pc, 64'h108);
    check_val("beq_we", out_we, 1'b0);
    set_op(7'h33, 3'd0, 7'h00, 64'h104, 64'd7, 64'd7, 64'd0, 5'd4);
    tick();
    check_val("wrong_path_drop", {out_valid, redirect_valid}, 2'b00);
    set_op(7'h63, 3'd0, 7'h00, 64'h100, 64'd3, 64'd4, 64'h8, 5'd0);
    tick();
    check_val("beq_not_taken", {out_valid, redirect_valid}, 2'b10);

    set_op(7'h63, 3'd4, 7'h00, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0);
    tick();
    check_val("blt_taken", redirect_valid, 1'b1);
    check_val("blt_target", redirect_pc, 64'hF8);
    in_valid = 1'b0; tick();
    set_op(7'h63, 3'd6, 7'h00, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 5'd0);
    tick();
    check_val("bltu_not_taken", redirect_valid, 1'b0);

    set_op(7'h67, 3'd0, 7'h00, 64'h40, 64'h201, 64'd0, 64'd0, 5'd1);
    tick();
    check_val("jalr_target", redirect_pc, 64'h200);
    check_val("jalr_link", out_result, 64'h44);
    check_val("jalr_we", out_we, 1'b1);
    in_valid = 1'b0; tick();
    set_op(7'h67, 3'd0, 7'h00, 64'h40, 64'h201, 64'd0, 64'd0, 5'd0);
    tick();
    check_val("jalr_rd0_we", out_we, 1'b0);
    in_valid = 1'b0; tick();

    // Stall: first entry accepted, then three cycles with downstream blocked
    out_ready = 1'b0;
    set_op(7'h33, 3'd4, 7'h00, 64'h0, 64'hF0F0, 64'h0FF0, 64'd0, 5'd9);
    saved = model(64);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_op(7'h13, 3'd0, 7'h00, 64'h0, 64'(i), 64'd0, 64'd100, 5'd10);
      tick();
      check_val("stall_in_ready", in_ready, 1'b0);
      check_val("stall_hold", out_result, saved.result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_op(7'h13, 3'd0, 7'h00, 64'h0, 64'(i * 3), 64'd0, 64'd100, 5'd11);
      tick();
    end

    set_op(7'h63, 3'd0, 7'h00, 64'h200, 64'd1, 64'd1, 64'h20, 5'd0);
    tick();
    flush = 1'b1;
    tick();
    check_val("flush_clear", {out_valid, redirect_valid}, 2'b00);
    flush = 1'b0;

    out_ready = 1'b0;
    set_op(7'h33, 3'd6, 7'h00, 64'h0, 64'h1234, 64'h8000, 64'd0, 5'd5);
    tick();
    in_valid = 1'b0; tick();
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", {out_valid, redirect_valid, out_we}, 3'd0);
    check_val("midrst_result", out_result, 64'd0);
    check_val("midrst_rd_flags", {out_rd, out_zero, out_carry, out_overflow}, 8'd0);
    check_val("midrst_redirect_pc", redirect_pc, 64'd0);
    m_valid = 1'b0; m_redir = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;

    // 32-bit instance: flush clears both slots so each op lands
    for (int i = 0; i < 13; i++) begin
      flush = 1'b1; tick();
      if (i == 0) set_op(7'h33, 3'd5, 7'h20, 64'h0, 64'h8000_0000, 64'd31, 64'd0, 5'd2);
      else begin rand_inputs(); in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; end
      tick();
      if (i == 0) check_val("xlen32_sra", s32_result, 32'hFFFF_FFFF);
      check_val("xlen32_valid", s32_out_valid, 1'b1);
      check_val("xlen32_result", s32_result, m32.result[31:0]);
      check_val("xlen32_we_flags", {s32_out_we, s32_zero, s32_carry, s32_ovf}, {m32.we, m32.z, m32.c, m32.v});
      check_val("xlen32_redirect", s32_redir, m32.redir);
      if (m32.redir) check_val("xlen32_redirect_pc", s32_redirect_pc, m32.tgt[31:0]);
    end

    for (int i = 0; i < 2500; i++) begin
      rand_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
